// File: rtl/stack_cpu_pkg.sv
// Shared opcode map, fault codes and FSM state encoding for stack_cpu_param.
package stack_cpu_pkg;

  localparam logic [7:0] OpLoad  = 8'h01;
  localparam logic [7:0] OpSwap  = 8'h02;
  localparam logic [7:0] OpDup   = 8'h03;
  localparam logic [7:0] OpDrop  = 8'h04;
  localparam logic [7:0] OpStore = 8'h10;
  localparam logic [7:0] OpAdd   = 8'h20;
  localparam logic [7:0] OpSub   = 8'h21;
  localparam logic [7:0] OpAnd   = 8'h22;
  localparam logic [7:0] OpOr    = 8'h23;
  localparam logic [7:0] OpXor   = 8'h24;
  localparam logic [7:0] OpSl    = 8'h25;
  localparam logic [7:0] OpLsr   = 8'h26;
  localparam logic [7:0] OpAsr   = 8'h27;
  localparam logic [7:0] OpLt    = 8'h28;
  localparam logic [7:0] OpJump  = 8'h30;
  localparam logic [7:0] OpJz    = 8'h31;
  localparam logic [7:0] OpJnz   = 8'h32;
  localparam logic [7:0] OpCall  = 8'h33;
  localparam logic [7:0] OpRet   = 8'h34;
  localparam logic [7:0] OpHalt  = 8'h3F;

  typedef enum logic [1:0] {
    FaultNone  = 2'd0,
    FaultOver  = 2'd1,
    FaultUnder = 2'd2,
    FaultCall  = 2'd3
  } fault_e;

  typedef enum logic [1:0] {
    StFill    = 2'd0,
    StRun     = 2'd1,
    StBusWait = 2'd2,
    StHalt    = 2'd3
  } state_e;

endpackage

// File: rtl/stack_file.sv
// Parametrised LIFO addressed by its occupancy count; the caller guarantees
// that push/pop/swap/wr_top are only requested when the count allows them.
module stack_file #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [1:0]                 pop_i,
  input  logic                       swap_i,
  input  logic                       wr_top_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           top_o,
  output logic [WIDTH-1:0]           next_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       has2_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_m1, cnt_m2, wr_pos;
  logic [AW-1:0]    top_idx, nxt_idx, push_idx;

  assign cnt_m1   = cnt_q - CW'(1);
  assign cnt_m2   = cnt_q - CW'(2);
  // wr_top after a pop lands on the entry that becomes the new top
  assign wr_pos   = cnt_m1 - CW'(pop_i);
  assign top_idx  = cnt_m1[AW-1:0];
  assign nxt_idx  = cnt_m2[AW-1:0];
  assign push_idx = cnt_q[AW-1:0];

  assign top_o   = mem_q[top_idx];
  assign next_o  = mem_q[nxt_idx];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign has2_o  = (cnt_q >= CW'(2));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (push_i) begin
      mem_q[push_idx] <= wdata_i;
      cnt_q           <= cnt_q + CW'(1);
    end else begin
      if (wr_top_i) begin
        mem_q[wr_pos[AW-1:0]] <= wdata_i;
      end else if (swap_i) begin
        mem_q[top_idx] <= mem_q[nxt_idx];
        mem_q[nxt_idx] <= mem_q[top_idx];
      end
      cnt_q <= cnt_q - CW'(pop_i);
    end
  end

endmodule

// File: rtl/stack_cpu_param.sv
// Stack CPU: opcode decode, pc, FILL/RUN/BUSWAIT/HALT control and the
// ready/valid data bus, built around a data stack and a call stack.
module stack_cpu_param
  import stack_cpu_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DDEPTH  = 4,
  parameter int unsigned CDEPTH  = 4,
  parameter int unsigned CODE_AW = 12
) (
  input  logic               clock,
  input  logic               reset,
  output logic [CODE_AW-1:0] code_addr,
  input  logic [7:0]         code_data,
  output logic               bus_valid,
  output logic               bus_write,
  output logic [WIDTH-1:0]   bus_addr,
  output logic [WIDTH-1:0]   bus_wr_data,
  input  logic               bus_ready,
  input  logic [WIDTH-1:0]   bus_rd_data,
  output logic               halted,
  output logic [1:0]         fault
);

  state_e             state_q, state_d;
  fault_e             fault_q, fault_d;
  logic [CODE_AW-1:0] pc_q, pc_d;
  logic               wait_wr_q, wait_wr_d;

  logic [WIDTH-1:0]            d_top, d_next, d_wdata;
  logic [$clog2(DDEPTH+1)-1:0] d_count;
  logic                        d_full, d_empty, d_has2, d_push, d_swap, d_wr;
  logic [1:0]                  d_pop;

  logic [CODE_AW-1:0]          c_top, c_next;
  logic [$clog2(CDEPTH+1)-1:0] c_count;
  logic                        c_full, c_empty, c_has2, c_push, c_pop;

  logic [1:0]         need;
  logic               dec_push, dec_swap, dec_wr, dec_cpush, dec_cpop;
  logic               dec_jump, dec_halt, dec_mem, dec_store;
  logic [1:0]         dec_pop;
  logic [WIDTH-1:0]   dec_wdata;
  logic [CODE_AW-1:0] rel_target, dec_target;
  fault_e             dec_fault;

  // Opcode at A executes while pc_q = A+1, so relative targets add to pc_q.
  assign rel_target = pc_q + d_top[CODE_AW-1:0];

  always_comb begin
    need       = 2'd0;
    dec_push   = 1'b0;
    dec_pop    = 2'd0;
    dec_swap   = 1'b0;
    dec_wr     = 1'b0;
    dec_wdata  = d_top;
    dec_cpush  = 1'b0;
    dec_cpop   = 1'b0;
    dec_jump   = 1'b0;
    dec_halt   = 1'b0;
    dec_mem    = 1'b0;
    dec_store  = 1'b0;
    dec_target = rel_target;
    if (code_data[7]) begin
      dec_push  = 1'b1;
      dec_wdata = {{(WIDTH-7){code_data[6]}}, code_data[6:0]};
    end else if (code_data[6]) begin
      need      = 2'd1;
      dec_wr    = 1'b1;
      dec_wdata = {d_top[WIDTH-7:0], code_data[5:0]};
    end else begin
      case (code_data)
        OpLoad:  begin need = 2'd1; dec_mem = 1'b1; end
        OpSwap:  begin need = 2'd2; dec_swap = 1'b1; end
        OpDup:   begin need = 2'd1; dec_push = 1'b1; end
        OpDrop:  begin need = 2'd1; dec_pop = 2'd1; end
        OpStore: begin need = 2'd2; dec_mem = 1'b1; dec_store = 1'b1; end
        OpAdd, OpSub, OpAnd, OpOr, OpXor: begin
          need    = 2'd2;
          dec_pop = 2'd1;
          dec_wr  = 1'b1;
          case (code_data)
            OpAdd:   dec_wdata = d_next + d_top;
            OpSub:   dec_wdata = d_next - d_top;
            OpAnd:   dec_wdata = d_next & d_top;
            OpOr:    dec_wdata = d_next | d_top;
            default: dec_wdata = d_next ^ d_top;
          endcase
        end
        OpSl:    begin need = 2'd1; dec_wr = 1'b1; dec_wdata = d_top << 1; end
        OpLsr:   begin need = 2'd1; dec_wr = 1'b1; dec_wdata = d_top >> 1; end
        OpAsr:   begin
          need = 2'd1; dec_wr = 1'b1; dec_wdata = {d_top[WIDTH-1], d_top[WIDTH-1:1]};
        end
        OpLt:    begin
          need = 2'd1; dec_wr = 1'b1; dec_wdata = {{(WIDTH-1){1'b0}}, d_top[WIDTH-1]};
        end
        OpJump:  begin need = 2'd1; dec_pop = 2'd1; dec_jump = 1'b1; end
        OpJz:    begin need = 2'd2; dec_pop = 2'd2; dec_jump = (d_next == '0); end
        OpJnz:   begin need = 2'd2; dec_pop = 2'd2; dec_jump = (d_next != '0); end
        OpCall:  begin need = 2'd1; dec_pop = 2'd1; dec_cpush = 1'b1; dec_jump = 1'b1; end
        OpRet:   begin dec_cpop = 1'b1; dec_jump = 1'b1; dec_target = c_top; end
        OpHalt:  dec_halt = 1'b1;
        default: ;
      endcase
    end
    if ((need == 2'd2 && !d_has2) || (need == 2'd1 && d_empty)) begin
      dec_fault = FaultUnder;
    end else if (dec_push && d_full) begin
      dec_fault = FaultOver;
    end else if ((dec_cpush && c_full) || (dec_cpop && c_empty)) begin
      dec_fault = FaultCall;
    end else begin
      dec_fault = FaultNone;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    fault_d   = fault_q;
    wait_wr_d = wait_wr_q;
    code_addr = pc_q;
    bus_valid = 1'b0;
    bus_write = 1'b0;
    d_push    = 1'b0;
    d_pop     = 2'd0;
    d_swap    = 1'b0;
    d_wr      = 1'b0;
    d_wdata   = dec_wdata;
    c_push    = 1'b0;
    c_pop     = 1'b0;
    unique case (state_q)
      StFill: begin
        code_addr = '0;
        pc_d      = CODE_AW'(1);
        state_d   = StRun;
      end
      StRun: begin
        if (dec_fault != FaultNone) begin
          fault_d = dec_fault;
          state_d = StHalt;
        end else if (dec_halt) begin
          state_d = StHalt;
        end else if (dec_mem) begin
          bus_valid = 1'b1;
          bus_write = dec_store;
          if (bus_ready) begin
            pc_d = pc_q + CODE_AW'(1);
            if (dec_store) begin
              d_pop = 2'd2;
            end else begin
              d_wr    = 1'b1;
              d_wdata = bus_rd_data;
            end
          end else begin
            wait_wr_d = dec_store;
            state_d   = StBusWait;
          end
        end else begin
          d_push = dec_push;
          d_pop  = dec_pop;
          d_swap = dec_swap;
          d_wr   = dec_wr;
          c_push = dec_cpush;
          c_pop  = dec_cpop;
          if (dec_jump) begin
            code_addr = dec_target;
          end
          pc_d = code_addr + CODE_AW'(1);
        end
      end
      StBusWait: begin
        bus_valid = 1'b1;
        bus_write = wait_wr_q;
        if (bus_ready) begin
          pc_d    = pc_q + CODE_AW'(1);
          state_d = StRun;
          if (wait_wr_q) begin
            d_pop = 2'd2;
          end else begin
            d_wr    = 1'b1;
            d_wdata = bus_rd_data;
          end
        end
      end
      StHalt: ;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StFill;
      pc_q      <= '0;
      fault_q   <= FaultNone;
      wait_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      fault_q   <= fault_d;
      wait_wr_q <= wait_wr_d;
    end
  end

  assign bus_addr    = d_top;
  assign bus_wr_data = d_next;
  assign halted      = (state_q == StHalt);
  assign fault       = fault_q;

  stack_file #(
    .WIDTH (WIDTH),
    .DEPTH (DDEPTH)
  ) u_dstack (
    .clk_i    (clock),
    .rst_i    (reset),
    .push_i   (d_push),
    .pop_i    (d_pop),
    .swap_i   (d_swap),
    .wr_top_i (d_wr),
    .wdata_i  (d_wdata),
    .top_o    (d_top),
    .next_o   (d_next),
    .count_o  (d_count),
    .full_o   (d_full),
    .empty_o  (d_empty),
    .has2_o   (d_has2)
  );

  stack_file #(
    .WIDTH (CODE_AW),
    .DEPTH (CDEPTH)
  ) u_cstack (
    .clk_i    (clock),
    .rst_i    (reset),
    .push_i   (c_push),
    .pop_i    ({1'b0, c_pop}),
    .swap_i   (1'b0),
    .wr_top_i (1'b0),
    .wdata_i  (pc_q),
    .top_o    (c_top),
    .next_o   (c_next),
    .count_o  (c_count),
    .full_o   (c_full),
    .empty_o  (c_empty),
    .has2_o   (c_has2)
  );

  logic unused_sigs;
  assign unused_sigs = ^{c_next, c_count, c_has2, d_count};

endmodule

// File: doc/stack_cpu_param.md
# stack_cpu_param

Parametrised successor to the 8-bit-opcode stack CPU: same opcode map, generalised data width, stack depths and code-address width. Adds CALL/RET, DUP/DROP, a ready/valid data bus that stalls on slow memory or IO, stack overflow/underflow detection with a fault halt, and an explicit HALT. Sits between an external synchronous code ROM and the system data bus.

## Interface
- WIDTH, 16: data width. Must be ≥ max(8, CODE_AW).
- DDEPTH, 4: data-stack entries. Power of 2, ≥ 2.
- CDEPTH, 4: call-stack entries. Power of 2, ≥ 2.
- CODE_AW, 12: code address width.
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- code_addr  out  CODE_AW  ROM fetch address, combinational.
- code_data  in  8  ROM data; 1-cycle synchronous read of code_addr.
- bus_valid  out  1  data request. Held until bus_ready.
- bus_write  out  1  1 = store, 0 = load.
- bus_addr  out  WIDTH  = S0.
- bus_wr_data  out  WIDTH  = S1.
- bus_ready  in  1  request accepted; for loads, bus_rd_data valid in the same cycle.
- bus_rd_data  in  WIDTH  load data.
- halted  out  1  CPU stopped (HALT or fault).
- fault  out  2  0 none, 1 data overflow, 2 data underflow, 3 call-stack over/underflow.

## Operation
- Opcode classes:
  - 1xxxxxxx: push sign-extend(op[6:0]).
  - 01xxxxxx: S0 ← {S0[WIDTH-7:0], op[5:0]}.
  - Otherwise family = op[7:4]; unlisted codes are NOPs.
- 0x0 family: 0x01 LOAD (S0 ← mem[S0]); 0x02 SWAP; 0x03 DUP (push S0); 0x04 DROP.
- 0x10 STORE: mem[S0] ← S1, pop 2.
- 0x2 family (binary ops pop 1, result replaces the new top): 0x20 ADD S1+S0, 0x21 SUB S1−S0, 0x22 AND, 0x23 OR, 0x24 XOR.
- 0x2 family (unary, in place): 0x25 SL, 0x26 LSR, 0x27 ASR, 0x28 LT (S0 ← sign bit of S0).
- Arithmetic wraps modulo 2^WIDTH.
- 0x3 family:
  - 0x30 JUMP: target = A+1+S0[CODE_AW-1:0] mod 2^CODE_AW, where A is the opcode address; pop 1.
  - 0x31 JZ, 0x32 JNZ: test S1, pop 2; jump relative to S0 if taken.
  - 0x33 CALL: push A+1 onto the call stack, pop 1, jump.
  - 0x34 RET: pop the call stack into pc.
  - 0x3F HALT.
- Stack checks run before any state update:
  - Operand count below the requirement (e.g. ADD with 1 entry) → fault 2.
  - Net push on a full data stack → fault 1.
  - CALL on a full call stack, or RET on an empty one → fault 3.
- On any fault, halted=1 and no state changes for the faulting opcode. Halted persists until reset.
- The stacks hold count registers 0..DEPTH; there is no silent wrap-around.

## Timing
- States: FILL, RUN, BUSWAIT, HALT.
- Reset → FILL. Reset values: pc=0, counts=0, halted=0, fault=0, bus_valid=0, bus_write=0, code_addr=0.
- FILL: one cycle; code_data is ignored; pc ← 1. Then → RUN.
- RUN: one opcode per cycle. code_addr = next pc (pc, or the jump target), so the following opcode arrives next cycle. Taken jumps incur no bubble.
- LOAD/STORE in RUN: assert bus_valid that cycle.
  - bus_ready the same cycle → complete, stay in RUN.
  - Otherwise → BUSWAIT.
- BUSWAIT: code_addr holds the address of the following opcode; bus_valid, bus_addr and bus_wr_data are stable. Completes on bus_ready, then → RUN.
- HALT: absorbing. bus_valid=0, code_addr frozen.
- Reset in any state, including mid-BUSWAIT, wins: bus_valid drops the next cycle.

## Structure
- Package stack_cpu_pkg holds:
  - opcode family/op localparams;
  - fault codes;
  - state encoding.
- One sub-module, stack_file: parametrised LIFO with params WIDTH and DEPTH.
  - Ports: push, pop, swap, wr_top, top/next outputs, count.
  - Flags: full, empty, has2.
  - Instantiated twice: data stack (WIDTH) and call stack (CODE_AW).
- Top module holds decode, pc, FSM and the bus handshake.

## Test plan
- Literals: ROM 0x85, 0x83, 0x21 (SUB), 0x11 (print-free) → S0 = 2, count = 1; 0x81, 0x41 → S0 = 0x0041.
- Bus stall: STORE with bus_ready low for 3 cycles → bus_valid held 4 cycles, addr/data stable, pc frozen; the next opcode executes the cycle after ready.
- CALL/RET: at A=0x10, push 5, CALL → executes at 0x16; RET returns to 0x11. Call depth CDEPTH+1 → fault 3, halted.
- Overflow: DDEPTH+1 literal pushes → fault 1 on the last push; count stays DDEPTH.
- Underflow: ADD on an empty stack → fault 2.
- JZ: JZ with S1=0 taken, S1=1 not taken; count −2 in both cases.
- Reset asserted mid-BUSWAIT → next cycle bus_valid=0, pc=0, FILL, first opcode at address 0.
